// File: rtl/id_ex_hazard_ctrl_if.sv
// ID/EX hazard-control bundle: ID operands, EX/MEM destinations, flush request,
// and the stall/bubble/forwarding controls returned to the pipeline.
interface id_ex_hazard_ctrl_if #(
   parameter int unsigned ADRS_W = 4,
   parameter int unsigned CNT_W  = 16
);
   logic              id_valid;
   logic [ADRS_W-1:0] id_src1;
   logic [ADRS_W-1:0] id_src2;
   logic              id_src1_used;
   logic              id_src2_used;
   logic              id_multicycle;
   logic              ex_wr_en;
   logic [ADRS_W-1:0] ex_dst;
   logic              ex_is_load;
   logic              mem_wr_en;
   logic [ADRS_W-1:0] mem_dst;
   logic              flush_req;
   logic              stall_if_id;
   logic              bubble_idex;
   logic [1:0]        fwd_sel1;
   logic [1:0]        fwd_sel2;
   logic              ex_busy;
   logic              mc_done;
   logic              proto_err;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_multicycle,
      output ex_wr_en, ex_dst, ex_is_load, mem_wr_en, mem_dst, flush_req,
      input  stall_if_id, bubble_idex, fwd_sel1, fwd_sel2, ex_busy, mc_done,
      input  proto_err, stall_cnt
   );

   modport slave (
      input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_multicycle,
      input  ex_wr_en, ex_dst, ex_is_load, mem_wr_en, mem_dst, flush_req,
      output stall_if_id, bubble_idex, fwd_sel1, fwd_sel2, ex_busy, mc_done,
      output proto_err, stall_cnt
   );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID->EX hazard controller: operand forwarding, load-use stalls, multi-cycle EX
// occupancy and branch-flush bubbles, plus a saturating stall-cycle counter.
module id_ex_hazard_ctrl #(
   parameter int unsigned ADRS_W    = 4,
   parameter int unsigned MC_CYCLES = 4,
   parameter int unsigned FLUSH_LEN = 2,
   parameter int unsigned CNT_W     = 16,
   parameter bit          ZERO_REG  = 1'b1
) (
   input logic               clock,
   input logic               reset,
   id_ex_hazard_ctrl_if.slave bus
);

   localparam int unsigned CntMax = (MC_CYCLES > FLUSH_LEN) ? MC_CYCLES : FLUSH_LEN;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] McLoad = CntW'(MC_CYCLES - 2);
   localparam logic [CntW-1:0] FlLoad = CntW'((FLUSH_LEN > 1) ? FLUSH_LEN - 2 : 0);

   typedef enum logic [1:0] {StRun, StMcBusy, StFlush} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             proto_err_q, proto_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       stall, bubble, busy, done;
   logic [1:0] fwd1, fwd2;
   logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2, load_use;

   function automatic logic hit(input logic used, input logic [ADRS_W-1:0] s,
                                input logic [ADRS_W-1:0] d);
      return used && (s == d) && !(ZERO_REG && (s == '0));
   endfunction

   function automatic logic [1:0] fwd_code(input logic ex_ok, input logic mem_ok);
      if (ex_ok) begin
         return 2'b01;
      end else if (mem_ok) begin
         return 2'b10;
      end
      return 2'b00;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      proto_err_d = proto_err_q;
      stall       = 1'b0;
      bubble      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      ex_hit1  = hit(bus.id_src1_used, bus.id_src1, bus.ex_dst);
      ex_hit2  = hit(bus.id_src2_used, bus.id_src2, bus.ex_dst);
      mem_hit1 = hit(bus.id_src1_used, bus.id_src1, bus.mem_dst) && bus.mem_wr_en;
      mem_hit2 = hit(bus.id_src2_used, bus.id_src2, bus.mem_dst) && bus.mem_wr_en;
      // A load in EX cannot forward; its value appears via the MEM path next cycle.
      fwd1     = fwd_code(ex_hit1 && bus.ex_wr_en && !bus.ex_is_load, mem_hit1);
      fwd2     = fwd_code(ex_hit2 && bus.ex_wr_en && !bus.ex_is_load, mem_hit2);
      load_use = bus.id_valid && bus.ex_wr_en && bus.ex_is_load && (ex_hit1 || ex_hit2);

      unique case (state_q)
         StRun: begin
            if (bus.flush_req) begin
               bubble = 1'b1;
               if (FLUSH_LEN > 1) begin
                  state_d = StFlush;
                  cnt_d   = FlLoad;
               end
            end else if (load_use) begin
               stall  = 1'b1;
               bubble = 1'b1;
            end else if (bus.id_valid && bus.id_multicycle) begin
               state_d = StMcBusy;
               cnt_d   = McLoad;
            end
         end
         StFlush: begin
            bubble = 1'b1;
            fwd1   = 2'b00;
            fwd2   = 2'b00;
            if (bus.flush_req) begin
               cnt_d = FlLoad;
            end else if (cnt_q == '0) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StMcBusy: begin
            busy   = 1'b1;
            stall  = 1'b1;
            bubble = 1'b1;
            // The op in EX cannot be squashed; a flush here is a protocol violation.
            if (bus.flush_req) begin
               proto_err_d = 1'b1;
            end
            if (cnt_q == '0) begin
               done    = 1'b1;
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = StRun;
            cnt_d   = '0;
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StRun;
         cnt_q       <= '0;
         proto_err_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         proto_err_q <= proto_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_if_id = stall & ~reset;
   assign bus.bubble_idex = bubble & ~reset;
   assign bus.fwd_sel1    = reset ? 2'b00 : fwd1;
   assign bus.fwd_sel2    = reset ? 2'b00 : fwd2;
   assign bus.ex_busy     = busy & ~reset;
   assign bus.mc_done     = done & ~reset;
   assign bus.proto_err   = proto_err_q;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule
